// File: rtl/mem_bus_pkg.sv
// ----------------------------------------------------------------------------
// mem_bus_pkg: shared types for the data-memory bus arbiter.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_bus_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2: combinational two-way round-robin pick; rrLast is owned by the caller.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rrLast,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = rrLast ? 2'b01 : 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter: shares the data-memory bus between the LSU (port 0) and DMA (port 1).   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int                RD_LATENCY = 1,
  parameter logic [ADDR_W-1:0] MEM_TOP    = 19'h40000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWrite,
  output logic              memRead,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  output logic              busy
);

  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             rr_last, rr_last_nx;
  logic             owner, owner_nx;
  logic             rd_err, rd_err_nx;

  logic [1:0] arb_req, arb_gnt, gnt_out;
  req_t       cur;
  logic       can_grant, granted, bus_act, in_range, rsp_valid;

  // The response cycle of a read is also a grant opportunity.
  assign can_grant = (state == IDLE) || (cnt == '0);
  assign arb_req   = {req1, req0} & {2{can_grant}};

  rr_arbiter2 u_arb (
    .req    (arb_req),
    .rrLast (rr_last),
    .gnt    (arb_gnt)
  );

  assign granted   = |arb_gnt;
  assign rsp_valid = (state == RD_WAIT) && (cnt == '0);

  always_comb begin
    cur.we    = we0;
    cur.addr  = addr0;
    cur.wdata = wdata0;
    if (arb_gnt[1]) begin
      cur.we    = we1;
      cur.addr  = addr1;
      cur.wdata = wdata1;
    end
  end

  assign in_range = cur.addr < MEM_TOP;

  // Output-side gating only: keeps every output low while rst_n is asserted.
  assign gnt_out = arb_gnt & {2{rst_n}};
  assign bus_act = granted & rst_n;

  always_comb begin
    gnt0     = gnt_out[0];
    gnt1     = gnt_out[1];
    memAddr  = bus_act ? cur.addr  : '0;
    memWdata = bus_act ? cur.wdata : '0;
    memWrite = bus_act &  cur.we & in_range;
    memRead  = bus_act & ~cur.we & in_range;
    rvalid0  = rsp_valid & ~owner;
    rvalid1  = rsp_valid &  owner;
    rdata0   = (rvalid0 && !rd_err) ? memRdata : '0;
    rdata1   = (rvalid1 && !rd_err) ? memRdata : '0;
    err0     = (gnt_out[0] & cur.we & ~in_range) | (rvalid0 & rd_err);
    err1     = (gnt_out[1] & cur.we & ~in_range) | (rvalid1 & rd_err);
    busy     = (state == RD_WAIT);
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    rr_last_nx = rr_last;
    owner_nx   = owner;
    rd_err_nx  = rd_err;
    if (state == RD_WAIT) begin
      if (cnt == '0) begin
        state_nx = IDLE;
      end else begin
        cnt_nx = cnt - 1'b1;
      end
    end
    if (granted) begin
      rr_last_nx = arb_gnt[1];
      if (!cur.we) begin
        // Out-of-range reads take a single RD_WAIT cycle to return the error.
        state_nx  = RD_WAIT;
        owner_nx  = arb_gnt[1];
        rd_err_nx = ~in_range;
        cnt_nx    = in_range ? CNT_W'(RD_LATENCY - 1) : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rr_last <= 1'b1;
      owner   <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rr_last <= rr_last_nx;
      owner   <= owner_nx;
      rd_err  <= rd_err_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_arbiter: randomized scoreboard bench for mem_bus_arbiter.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int                LAT = 3;
  localparam logic [ADDR_W-1:0] TOP = 19'h40000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        req = 2'b00;
  logic [1:0]        we  = 2'b00;
  logic [ADDR_W-1:0] addr  [2];
  logic [DATA_W-1:0] wdata [2];
  logic [1:0]        gnt, rvalid, err;
  logic [DATA_W-1:0] rdata [2];
  logic [ADDR_W-1:0] memAddr;
  logic              memWrite, memRead, busy;
  logic [DATA_W-1:0] memWdata, memRdata;

  mem_bus_arbiter #(.RD_LATENCY(LAT), .MEM_TOP(TOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
    .gnt0(gnt[0]), .rvalid0(rvalid[0]), .rdata0(rdata[0]), .err0(err[0]),
    .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
    .gnt1(gnt[1]), .rvalid1(rvalid[1]), .rdata1(rdata[1]), .err1(err[1]),
    .memAddr(memAddr), .memWrite(memWrite), .memRead(memRead),
    .memWdata(memWdata), .memRdata(memRdata), .busy(busy)
  );

  function automatic logic [DATA_W-1:0] hash(input logic [ADDR_W-1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Memory whose data is valid exactly LAT cycles after a read strobe, garbage otherwise.
  logic [ADDR_W-1:0] m_addr = '0;
  int                m_age  = 99;
  always @(posedge clk) begin
    if (memRead) begin
      m_addr <= memAddr;
      m_age  <= 1;
    end else if (m_age < 99) begin
      m_age <= m_age + 1;
    end
  end
  assign memRdata = (m_age == LAT) ? hash(m_addr) : (32'hBAD00000 | 32'(m_age));

  typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; } item_t;
  typedef struct { logic [DATA_W-1:0] data; logic err; } rsp_t;
  item_t gq [2][$];
  rsp_t  rq [2][$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: grant any request when no read is outstanding (or in its
  // response cycle); on a tie the port not granted last wins.
  bit   mon_en = 1'b0;
  int   cyc    = 0;
  bit   pend   = 1'b0;
  int   due    = 0;
  logic pown   = 1'b0;
  logic last   = 1'b1;

  always @(negedge clk) begin : mon
    logic [1:0]        eg, erv, eerr;
    logic [DATA_W-1:0] erd [2];
    logic              allowed, inr;
    item_t             it;
    rsp_t              r;
    int                w;
    if (mon_en) begin
      cyc++;
      erv = '0; eerr = '0; erd[0] = '0; erd[1] = '0;
      allowed = !pend || (cyc == due);
      chk("busy", busy, pend);
      if (pend && cyc == due) begin
        erv[pown] = 1'b1;
        if (rq[pown].size() == 0) chk("rsp_queue", 0, 1);
        else begin
          r = rq[pown].pop_front();
          erd[pown]  = r.data;
          eerr[pown] = r.err;
        end
        pend = 1'b0;
      end
      eg = 2'b00;
      if (allowed) eg = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
      chk("gnt", gnt, eg);
      if (eg != 2'b00) begin
        w    = eg[1] ? 1 : 0;
        last = eg[1];
        if (gq[w].size() == 0) chk("gnt_queue", 0, 1);
        else begin
          it  = gq[w].pop_front();
          inr = it.addr < TOP;
          chk("memAddr",  memAddr,  it.addr);
          chk("memWdata", memWdata, it.wdata);
          chk("memWrite", memWrite, it.we && inr);
          chk("memRead",  memRead,  !it.we && inr);
          if (it.we && !inr) eerr[w] = 1'b1;
          if (!it.we) begin
            pend = 1'b1;
            pown = eg[1];
            due  = cyc + (inr ? LAT : 1);
          end
        end
      end else begin
        chk("idle_bus", {memAddr, memWdata, memWrite, memRead}, 64'd0);
      end
      chk("rvalid", rvalid, erv);
      chk("err", err, eerr);
      chk("rdata0", rdata[0], erd[0]);
      chk("rdata1", rdata[1], erd[1]);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Blocking master: holds the request until granted, then waits out any read.
  task automatic issue(input int p, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    item_t it;
    rsp_t  r;
    bit    got;
    it.we = w; it.addr = a; it.wdata = d;
    gq[p].push_back(it);
    if (!w) begin
      r.err  = !(a < TOP);
      r.data = r.err ? '0 : hash(a);
      rq[p].push_back(r);
    end
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = gnt[p];
    end
    @(posedge clk); #1;
    req[p] = 1'b0;
    if (!got) begin
      chk("gnt_timeout", 0, 1);
      gq[p].delete();
      rq[p].delete();
    end else if (!w) begin
      for (int k = 0; k < 50 && rq[p].size() != 0; k++) begin @(posedge clk); #1; end
      if (rq[p].size() != 0) begin
        chk("rsp_timeout", 0, 1);
        rq[p].delete();
      end
    end
  endtask

  task automatic master(input int p);
    repeat (120) begin
      logic              w;
      logic [ADDR_W-1:0] a;
      int                sel;
      w   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = TOP + 19'($urandom_range(0, 32'h3FFFF));
      else if (sel < 3)  a = 19'($urandom_range(0, 15));
      else               a = 19'($urandom_range(0, 32'h3FFFF));
      issue(p, w, a, $urandom);
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    addr[0] = 19'd10; addr[1] = 19'd20; wdata[0] = '0; wdata[1] = '0;
    req = 2'b11; we = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_gnt",   gnt, 2'b00);
    chk("rst_bus",   {memAddr, memWrite, memRead, busy}, 64'd0);
    chk("rst_wdata", memWdata, 64'd0);
    chk("rst_rsp",   {rvalid, err}, 64'd0);
    chk("rst_rdata", {rdata[0], rdata[1]}, 64'd0);
    req = 2'b00;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    issue(0, 1'b1, 19'd50, 32'hA5);

    fork
      begin repeat (2) issue(0, 1'b0, 19'($urandom_range(0, 32'hFFFF)), $urandom); end
      begin repeat (2) issue(1, 1'b0, 19'($urandom_range(0, 32'hFFFF)), $urandom); end
    join

    fork
      issue(1, 1'b0, 19'd77, $urandom);
      begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (gnt[1]) break;
        end
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 19'd5;
        @(posedge clk); #1;
        req[0] = 1'b0;
        issue(0, 1'b0, 19'd88, $urandom);
      end
    join

    issue(1, 1'b1, TOP, $urandom);
    issue(1, 1'b0, TOP + 19'd5, $urandom);
    issue(0, 1'b0, 19'h7FFFF, $urandom);
    issue(0, 1'b1, TOP - 19'd1, $urandom);
    issue(0, 1'b0, TOP - 19'd1, $urandom);

    issue(0, 1'b1, 19'd50, $urandom);
    issue(0, 1'b1, 19'd77, $urandom);

    fork
      master(0);
      master(1);
    join
    idle(4);

    // Reset in the middle of a port-0 read.
    mon_en = 1'b0;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 19'd77;
    @(negedge clk);
    chk("t5_gnt", gnt, 2'b01);
    chk("t5_memRead", memRead, 1'b1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    chk("t5_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ctl", {gnt, rvalid, err, busy, memWrite, memRead}, 64'd0);
    chk("t5_rst_bus", {memAddr, memWdata}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_no_rvalid", {rvalid, err, busy}, 64'd0);
      chk("t5_no_rdata", {rdata[0], rdata[1]}, 64'd0);
    end
    @(posedge clk); #1;
    req = 2'b11; we = 2'b11; addr[0] = 19'd50; addr[1] = 19'd77;
    @(negedge clk);
    chk("t5_tie", gnt, 2'b01);
    @(posedge clk); #1;
    req = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
